buff_desc_overlay: RTL
======================

Name: buff_desc_overlay

Overview:
- Upstream/downstream wrapper stage around the buff-description ROM drawer.
- Decides when a buff description box is visible, and latches the buff type only on frame boundaries.
- Generates box-local x/y coordinates and type for the drawer.
- Composites the returned pixel over the background stream with a fixed, aligned latency.
- Sits in the VGA pixel pipeline between the background layer mux and the final RGB output register.

Parameters:
- BOX_X, 274, screen x of box top-left pixel
- BOX_Y, 40, screen y of box top-left pixel
- BOX_W, 92, box width in pixels (matches description bitmap width)
- BOX_H, 42, box height in pixels (matches bitmap height per type)
- SHOW_FRAMES, 120, number of whole frames a description stays visible
- KEY_COLOR, 24'hFF00FF, transparent colour in description bitmap
- V_ACTIVE, 480, first non-visible line number (frame boundary line)

Ports:
- vga_clk  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- show_req  in  1  single-cycle pulse from game logic requesting a description
- buff_type_in  in  2  buff type sampled with show_req (0,1,2; 3 treated as 2)
- hcount  in  10  current pixel column
- vcount  in  10  current pixel row
- bg_rgb  in  24  background pixel aligned with hcount/vcount
- desc_x  out  7  box-local column to drawer, registered
- desc_y  out  7  box-local row to drawer, registered
- desc_type  out  2  active buff type to drawer, registered
- desc_rgb  in  24  drawer pixel; valid one cycle after desc_x/desc_y
- out_rgb  out  24  composited pixel, registered
- visible  out  1  high while a description is displayed

Behaviour:
- Reset (synchronous, active-high): state IDLE; pending=0, frame counter=0, desc_x=0, desc_y=0, desc_type=0, out_rgb=0, visible=0; pipeline valid bits cleared. Reset mid-display blanks the box on the next cycle.
- Frame boundary (fb): single cycle where hcount==0 && vcount==V_ACTIVE.
- Request latch: show_req=1 sets pending=1 and pend_type=buff_type_in, in any state. The last request before an fb wins.
- States:
  - IDLE: on fb with pending (including a show_req in the same cycle) -> SHOWING; load desc_type=pend_type, counter=SHOW_FRAMES, clear pending.
  - SHOWING: visible=1. On fb with pending -> reload type and counter, stay SHOWING (restart). On fb without pending: if counter==1 -> IDLE, else counter-1.
- Result: the box is shown for exactly SHOW_FRAMES full frames, and never changes type mid-frame.
- SHOW_FRAMES==0 is illegal; an assertion is required.
- Pipeline (input at cycle t):
  - t+1: in_box = SHOWING && BOX_X<=hcount<BOX_X+BOX_W && BOX_Y<=vcount<BOX_Y+BOX_H.
  - t+1: desc_x = hcount-BOX_X and desc_y = vcount-BOX_Y, truncated to 7 bits when in_box; else 0.
  - t+1: bg_rgb and in_box are registered alongside.
  - t+2: drawer returns desc_rgb; bg and in_box are delayed a second stage.
  - t+3: out_rgb = (in_box_d2 && desc_rgb!=KEY_COLOR) ? desc_rgb : bg_d2.
  - Total latency: 3 cycles, constant, including outside active video.
- in_box uses the state at cycle t. A state change at fb therefore only affects pixels from the fb cycle onward, which are all in blanking.
- Width rule: comparisons are done on 10-bit unsigned values; no wrap occurs because BOX_X+BOX_W<=640 and BOX_Y+BOX_H<=V_ACTIVE. Both limits require assertions.

Decomposition:
- Shared package buff_pkg holds:
  - buff_t enum (ATTACK=0, DEFENSE=1, HEAL=2);
  - BUFF_DESC_W=92 and BUFF_DESC_H=42;
  - KEY_COLOR;
  - overlay state typedef {IDLE, SHOWING}.
- One natural sub-module, buff_desc_timer: fb detect, pending latch, state machine and frame counter; outputs visible and active type.
- Pixel pipeline and compositing stay in the top module.
- The drawer is instantiated by the parent, not inside this block.

Test Plan:
- Reset, then drive a full frame with no request -> visible=0, out_rgb equals bg_rgb delayed 3 cycles, desc_x/desc_y stay 0.
- show_req with type 1 mid-frame -> visible rises at next fb, not before. At hcount=274, vcount=40 the bench sees desc_x=0, desc_y=0 at t+1. out_rgb at t+3 equals the model ROM pixel.
- SHOW_FRAMES=3 -> visible high for exactly 3 fb-to-fb frames, then low from the 3rd subsequent fb.
- show_req type 0 then type 2 in the same frame -> desc_type=2 after fb. A type-1 request during SHOWING restarts the counter at the next fb with desc_type=1.
- Model drawer returns KEY_COLOR for x<10 inside the box -> out_rgb shows bg there and the drawer pixel elsewhere in the box. Pixel (366,40), just outside the box, shows bg.
- Assert reset mid-frame while SHOWING -> next cycle visible=0 and desc_type=0; out_rgb=0 one cycle after reset; a pending request is cleared.

Source files
------------

// File: rtl/buff_pkg.sv
// Shared buff types, description bitmap geometry and overlay state encoding.
// Imported by the overlay top, its frame timer and the description drawer.
package buff_pkg;

    typedef enum logic [1:0] {
        ATTACK  = 2'd0,
        DEFENSE = 2'd1,
        HEAL    = 2'd2
    } buff_t;

    typedef enum logic {
        IDLE    = 1'b0,
        SHOWING = 1'b1
    } overlay_state_t;

    localparam int          BUFF_DESC_W = 92;
    localparam int          BUFF_DESC_H = 42;
    localparam logic [23:0] KEY_COLOR   = 24'hFF00FF;

    // Code 3 is not a real buff; it folds onto HEAL.
    function automatic buff_t to_buff(input logic [1:0] code);
        return (code == 2'd3) ? HEAL : buff_t'(code);
    endfunction

endpackage

// File: rtl/buff_desc_overlay_if.sv
// Pixel-stream, request and drawer signals of the buff description overlay.
// master = pixel source / game logic / drawer side, slave = overlay.
interface buff_desc_overlay_if;
    logic        show_req;
    logic [1:0]  buff_type_in;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [23:0] bg_rgb;
    logic [6:0]  desc_x;
    logic [6:0]  desc_y;
    logic [1:0]  desc_type;
    logic [23:0] desc_rgb;
    logic [23:0] out_rgb;
    logic        visible;

    modport master (
        output show_req, buff_type_in, hcount, vcount, bg_rgb, desc_rgb,
        input  desc_x, desc_y, desc_type, out_rgb, visible
    );

    modport slave (
        input  show_req, buff_type_in, hcount, vcount, bg_rgb, desc_rgb,
        output desc_x, desc_y, desc_type, out_rgb, visible
    );
endinterface

// File: rtl/buff_desc_timer.sv
// Frame-boundary request latch and visibility timer for the description box.
// State and type change only on the frame-boundary cycle; no backpressure.
module buff_desc_timer
    import buff_pkg::*;
#(
    parameter int SHOW_FRAMES = 120,
    parameter int V_ACTIVE    = 480
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       show_req,
    input  logic [1:0] buff_type_in,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    output logic       visible,
    output buff_t      active_type
);

    localparam int         CNT_W   = $clog2(SHOW_FRAMES + 1);
    localparam logic [9:0] FB_LINE = 10'(V_ACTIVE);

    overlay_state_t   state;
    logic             pending;
    buff_t            pend_type;
    logic [CNT_W-1:0] frame_cnt;
    logic             fb;

    assign fb      = (hcount == 10'd0) && (vcount == FB_LINE);
    assign visible = (state == SHOWING);

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state       <= IDLE;
            pending     <= 1'b0;
            pend_type   <= ATTACK;
            frame_cnt   <= '0;
            active_type <= ATTACK;
        end else if (fb && (pending || show_req)) begin
            // A request arriving on the boundary cycle itself counts as pending.
            state       <= SHOWING;
            active_type <= show_req ? to_buff(buff_type_in) : pend_type;
            frame_cnt   <= CNT_W'(SHOW_FRAMES);
            pending     <= 1'b0;
        end else begin
            if (show_req) begin
                pending   <= 1'b1;
                pend_type <= to_buff(buff_type_in);
            end
            case (state)
                IDLE: ;
                SHOWING: begin
                    if (fb) begin
                        if (frame_cnt == CNT_W'(1))
                            state <= IDLE;
                        else
                            frame_cnt <= frame_cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    show_frames_nonzero: assert property (@(posedge vga_clk) SHOW_FRAMES != 0);

endmodule

// File: rtl/buff_desc_overlay.sv
// Buff description box overlay: drives drawer coordinates and composites its pixel.
// Latency 3 cycles bg_rgb -> out_rgb, constant in all regions; no backpressure.
module buff_desc_overlay
    import buff_pkg::*;
#(
    parameter int BOX_X       = 274,
    parameter int BOX_Y       = 40,
    parameter int BOX_W       = BUFF_DESC_W,
    parameter int BOX_H       = BUFF_DESC_H,
    parameter int SHOW_FRAMES = 120,
    parameter int V_ACTIVE    = 480
) (
    input  logic                vga_clk,
    input  logic                reset,
    buff_desc_overlay_if.slave  bus
);

    localparam logic [9:0] X_LO = 10'(BOX_X);
    localparam logic [9:0] X_HI = 10'(BOX_X + BOX_W);
    localparam logic [9:0] Y_LO = 10'(BOX_Y);
    localparam logic [9:0] Y_HI = 10'(BOX_Y + BOX_H);

    logic        showing;
    buff_t       act_type;
    logic        in_box_c;
    logic        in_box_d1, in_box_d2;
    logic [23:0] bg_d1, bg_d2;

    buff_desc_timer #(
        .SHOW_FRAMES (SHOW_FRAMES),
        .V_ACTIVE    (V_ACTIVE)
    ) u_timer (
        .vga_clk      (vga_clk),
        .reset        (reset),
        .show_req     (bus.show_req),
        .buff_type_in (bus.buff_type_in),
        .hcount       (bus.hcount),
        .vcount       (bus.vcount),
        .visible      (showing),
        .active_type  (act_type)
    );

    assign bus.visible   = showing;
    assign bus.desc_type = act_type;

    // Uses the state seen in the same cycle as the pixel coordinates.
    assign in_box_c = showing
                   && (bus.hcount >= X_LO) && (bus.hcount < X_HI)
                   && (bus.vcount >= Y_LO) && (bus.vcount < Y_HI);

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            in_box_d1   <= 1'b0;
            in_box_d2   <= 1'b0;
            bg_d1       <= '0;
            bg_d2       <= '0;
            bus.desc_x  <= '0;
            bus.desc_y  <= '0;
            bus.out_rgb <= '0;
        end else begin
            in_box_d1  <= in_box_c;
            bg_d1      <= bus.bg_rgb;
            bus.desc_x <= in_box_c ? 7'(bus.hcount - X_LO) : 7'd0;
            bus.desc_y <= in_box_c ? 7'(bus.vcount - Y_LO) : 7'd0;
            // Drawer answers during this stage; bg and in_box wait alongside it.
            in_box_d2  <= in_box_d1;
            bg_d2      <= bg_d1;
            bus.out_rgb <= (in_box_d2 && (bus.desc_rgb != KEY_COLOR)) ? bus.desc_rgb : bg_d2;
        end
    end

    box_x_fits: assert property (@(posedge vga_clk) (BOX_X + BOX_W) <= 640);
    box_y_fits: assert property (@(posedge vga_clk) (BOX_Y + BOX_H) <= V_ACTIVE);

endmodule
